// File: rtl/sram_access_arbiter.sv
// rtl/sram_access_arbiter.sv - three-requester async SRAM access arbiter with read/write sequencer
//
// Ports:
//   CLK, RST                        clock, asynchronous active-high reset
//   CAP_REQ/ADR/WD -> CAP_ACK       capture port, always writes, highest priority
//   USB_REQ/ADR -> USB_RD/USB_ACK   readout port, always reads
//   MAT_REQ/WE/ADR/WD -> MAT_RD/ACK matcher port, read or write
//   ADX, DX, CEX, CEY               SRAM address, data bus, OE_n, WE_n
//   CE1, CE2, BHE, BLE              static chip/byte enables
//   GRANT, BUSY                     current owner (0 none, 1 CAP, 2 USB, 3 MAT), not-idle flag
module sram_access_arbiter #(
    parameter int RD_WAIT  = 2,
    parameter int WR_PULSE = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CAP_REQ,
    input  logic [19:0] CAP_ADR,
    input  logic [15:0] CAP_WD,
    output logic        CAP_ACK,
    input  logic        USB_REQ,
    input  logic [19:0] USB_ADR,
    output logic [15:0] USB_RD,
    output logic        USB_ACK,
    input  logic        MAT_REQ,
    input  logic        MAT_WE,
    input  logic [19:0] MAT_ADR,
    input  logic [15:0] MAT_WD,
    output logic [15:0] MAT_RD,
    output logic        MAT_ACK,
    output logic [19:0] ADX,
    inout  wire  [15:0] DX,
    output logic        CEX,
    output logic        CEY,
    output logic        CE1,
    output logic        CE2,
    output logic        BHE,
    output logic        BLE,
    output logic [1:0]  GRANT,
    output logic        BUSY
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RSET   = 3'd1,
        RWAIT  = 3'd2,
        RSAMP  = 3'd3,
        WSET   = 3'd4,
        WPULSE = 3'd5,
        WHOLD  = 3'd6
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CAP  = 2'd1;
    localparam logic [1:0] OWN_USB  = 2'd2;
    localparam logic [1:0] OWN_MAT  = 2'd3;

    localparam logic [3:0] RD_LAST = 4'(RD_WAIT - 1);
    localparam logic [3:0] WR_LAST = 4'(WR_PULSE - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [19:0] adr_q, adr_d;
    logic [15:0] wd_q, wd_d;
    logic [1:0]  owner_q, owner_d;
    // 1 = MAT wins the next USB/MAT tie, 0 = USB wins
    logic        rr_mat_q, rr_mat_d;
    logic [15:0] usb_rd_q, usb_rd_d;
    logic [15:0] mat_rd_q, mat_rd_d;

    logic        write_phase;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            adr_q    <= 20'd0;
            wd_q     <= 16'd0;
            owner_q  <= OWN_NONE;
            rr_mat_q <= 1'b0;
            usb_rd_q <= 16'd0;
            mat_rd_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            adr_q    <= adr_d;
            wd_q     <= wd_d;
            owner_q  <= owner_d;
            rr_mat_q <= rr_mat_d;
            usb_rd_q <= usb_rd_d;
            mat_rd_q <= mat_rd_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        adr_d    = adr_q;
        wd_d     = wd_q;
        owner_d  = owner_q;
        rr_mat_d = rr_mat_q;
        usb_rd_d = usb_rd_q;
        mat_rd_d = mat_rd_q;

        case (state_q)
            IDLE: begin
                cnt_d = 4'd0;
                if (CAP_REQ) begin
                    owner_d = OWN_CAP;
                    adr_d   = CAP_ADR;
                    wd_d    = CAP_WD;
                    state_d = WSET;
                end else if (USB_REQ && (!MAT_REQ || !rr_mat_q)) begin
                    owner_d  = OWN_USB;
                    adr_d    = USB_ADR;
                    rr_mat_d = 1'b1;
                    state_d  = RSET;
                end else if (MAT_REQ) begin
                    owner_d  = OWN_MAT;
                    adr_d    = MAT_ADR;
                    wd_d     = MAT_WD;
                    rr_mat_d = 1'b0;
                    state_d  = MAT_WE ? WSET : RSET;
                end
            end
            RSET: begin
                cnt_d   = 4'd0;
                state_d = RWAIT;
            end
            RWAIT: begin
                if (cnt_q == RD_LAST) begin
                    state_d = RSAMP;
                    // Bus is sampled on the edge into RSAMP so the data is
                    // already on the owner's RD output while ACK is high.
                    if (owner_q == OWN_USB) begin
                        usb_rd_d = DX;
                    end else begin
                        mat_rd_d = DX;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RSAMP: begin
                state_d = IDLE;
            end
            WSET: begin
                cnt_d   = 4'd0;
                state_d = WPULSE;
            end
            WPULSE: begin
                if (cnt_q == WR_LAST) begin
                    state_d = WHOLD;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WHOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign write_phase = (state_q == WSET) || (state_q == WPULSE) || (state_q == WHOLD);

    // RST terms make the strobes safe combinationally, not just after the
    // state register clears.
    assign CEX = RST | write_phase;
    assign CEY = RST | (state_q != WPULSE);
    assign DX  = (write_phase && !RST) ? wd_q : 16'bz;
    assign ADX = adr_q;

    assign CE1 = 1'b0;
    assign CE2 = 1'b1;
    assign BHE = 1'b0;
    assign BLE = 1'b0;

    assign CAP_ACK = (state_q == WHOLD) && (owner_q == OWN_CAP);
    assign USB_ACK = (state_q == RSAMP) && (owner_q == OWN_USB);
    assign MAT_ACK = ((state_q == RSAMP) || (state_q == WHOLD)) && (owner_q == OWN_MAT);

    assign USB_RD = usb_rd_q;
    assign MAT_RD = mat_rd_q;

    assign GRANT = (state_q == IDLE) ? OWN_NONE : owner_q;
    assign BUSY  = (state_q != IDLE);

endmodule

// File: tb/tb_sram_access_arbiter.sv
// tb/tb_sram_access_arbiter.sv - directed bench for sram_access_arbiter
module tb_sram_access_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        CAP_REQ = 0, USB_REQ = 0, MAT_REQ = 0, MAT_WE = 0;
    logic [19:0] CAP_ADR = 0, USB_ADR = 0, MAT_ADR = 0;
    logic [15:0] CAP_WD = 0, MAT_WD = 0;
    logic        CAP_ACK, USB_ACK, MAT_ACK;
    logic [15:0] USB_RD, MAT_RD;
    logic [19:0] ADX;
    wire  [15:0] DX;
    logic        CEX, CEY, CE1, CE2, BHE, BLE, BUSY;
    logic [1:0]  GRANT;

    logic        b_CAP_REQ = 0, b_USB_REQ = 0;
    logic [15:0] b_CAP_WD = 16'hC3C3;
    logic        b_CAP_ACK, b_USB_ACK, b_MAT_ACK;
    logic [15:0] b_USB_RD, b_MAT_RD;
    logic [19:0] b_ADX;
    wire  [15:0] b_DX;
    logic        b_CEX, b_CEY, b_CE1, b_CE2, b_BHE, b_BLE, b_BUSY;
    logic [1:0]  b_GRANT;

    always #5 CLK = ~CLK;

    sram_access_arbiter #(.RD_WAIT(2), .WR_PULSE(2)) dut (
        .CLK(CLK), .RST(RST),
        .CAP_REQ(CAP_REQ), .CAP_ADR(CAP_ADR), .CAP_WD(CAP_WD), .CAP_ACK(CAP_ACK),
        .USB_REQ(USB_REQ), .USB_ADR(USB_ADR), .USB_RD(USB_RD), .USB_ACK(USB_ACK),
        .MAT_REQ(MAT_REQ), .MAT_WE(MAT_WE), .MAT_ADR(MAT_ADR), .MAT_WD(MAT_WD),
        .MAT_RD(MAT_RD), .MAT_ACK(MAT_ACK),
        .ADX(ADX), .DX(DX), .CEX(CEX), .CEY(CEY), .CE1(CE1), .CE2(CE2),
        .BHE(BHE), .BLE(BLE), .GRANT(GRANT), .BUSY(BUSY)
    );

    sram_access_arbiter #(.RD_WAIT(15), .WR_PULSE(1)) dut_b (
        .CLK(CLK), .RST(RST),
        .CAP_REQ(b_CAP_REQ), .CAP_ADR(20'h00200), .CAP_WD(b_CAP_WD), .CAP_ACK(b_CAP_ACK),
        .USB_REQ(b_USB_REQ), .USB_ADR(20'h00300), .USB_RD(b_USB_RD), .USB_ACK(b_USB_ACK),
        .MAT_REQ(1'b0), .MAT_WE(1'b0), .MAT_ADR(20'h0), .MAT_WD(16'h0),
        .MAT_RD(b_MAT_RD), .MAT_ACK(b_MAT_ACK),
        .ADX(b_ADX), .DX(b_DX), .CEX(b_CEX), .CEY(b_CEY), .CE1(b_CE1), .CE2(b_CE2),
        .BHE(b_BHE), .BLE(b_BLE), .GRANT(b_GRANT), .BUSY(b_BUSY)
    );

    // SRAM models: drive the bus while OE_n low and WE_n high, store on WE_n low
    logic [15:0] mem [0:1048575];
    assign DX   = (!CEX && CEY) ? mem[ADX] : 16'bz;
    assign b_DX = (!b_CEX && b_CEY) ? 16'h5A5A : 16'bz;

    always @(posedge CLK) begin
        if (!RST && !CEY && CEX) mem[ADX] <= DX;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        cap, usb, mat, mat_we;
        logic [19:0] adr;
        logic [15:0] wd;
        logic [1:0]  exp_grant;
        logic        exp_wr;
        int          exp_lat;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs [6];

    task automatic run_vec(input int idx);
        vec_t v;
        int lat, cey_lo;
        logic bad_grant, bad_wr, bad_ack, own_ack;
        logic [19:0] adx_at_ack;
        logic [15:0] rd_at_ack;
        v = vecs[idx];
        lat = -1; cey_lo = 0; bad_grant = 0; bad_wr = 0; bad_ack = 0;
        adx_at_ack = 0; rd_at_ack = 0;
        @(posedge CLK); #1;
        CAP_ADR = v.adr; USB_ADR = v.adr; MAT_ADR = v.adr;
        CAP_WD = v.wd; MAT_WD = v.wd; MAT_WE = v.mat_we;
        CAP_REQ = v.cap; USB_REQ = v.usb; MAT_REQ = v.mat;
        for (int n = 0; n < 40; n++) begin
            @(negedge CLK);
            if (n == 0 && GRANT !== 2'd0) bad_grant = 1;
            if (n > 0 && GRANT !== v.exp_grant) bad_grant = 1;
            if (n > 0 && CEY === 1'b0) cey_lo++;
            if (n > 0 && v.exp_wr && (DX !== v.wd || CEX !== 1'b1)) bad_wr = 1;
            own_ack = (v.exp_grant == 2'd1) ? CAP_ACK : (v.exp_grant == 2'd2) ? USB_ACK : MAT_ACK;
            if (($countones({CAP_ACK, USB_ACK, MAT_ACK}) - int'(own_ack)) != 0) bad_ack = 1;
            if (own_ack) begin
                lat = n;
                adx_at_ack = ADX;
                rd_at_ack = (v.exp_grant == 2'd2) ? USB_RD : MAT_RD;
                break;
            end
        end
        @(posedge CLK); #1;
        CAP_REQ = 0; USB_REQ = 0; MAT_REQ = 0;
        check($sformatf("vec%0d latency", idx), lat, v.exp_lat);
        check($sformatf("vec%0d grant", idx), {31'd0, bad_grant}, 0);
        check($sformatf("vec%0d cey_low_cycles", idx), cey_lo, v.exp_wr ? 2 : 0);
        check($sformatf("vec%0d write_bus", idx), {31'd0, bad_wr}, 0);
        check($sformatf("vec%0d other_ack", idx), {31'd0, bad_ack}, 0);
        check($sformatf("vec%0d adx", idx), {12'd0, adx_at_ack}, {12'd0, v.adr});
        if (!v.exp_wr) check($sformatf("vec%0d rd_data", idx), {16'd0, rd_at_ack}, {16'd0, v.exp_rd});
    endtask

    int   order [$];
    logic overlap;

    task automatic arb_run(input int n_acks, input int usb_acks_before_drop);
        logic [2:0] a;
        int usb_seen;
        order.delete();
        overlap = 0;
        usb_seen = 0;
        for (int c = 0; c < 80 && order.size() < n_acks; c++) begin
            @(negedge CLK);
            a = {CAP_ACK, USB_ACK, MAT_ACK};
            if ($countones(a) > 1) overlap = 1;
            if (a[2]) order.push_back(1);
            if (a[1]) begin order.push_back(2); usb_seen++; end
            if (a[0]) order.push_back(3);
            @(posedge CLK); #1;
            if (a[2]) CAP_REQ = 0;
            if (a[0]) MAT_REQ = 0;
            if (a[1] && usb_seen >= usb_acks_before_drop) USB_REQ = 0;
        end
        CAP_REQ = 0; USB_REQ = 0; MAT_REQ = 0;
        repeat (3) @(posedge CLK);
        #1;
    endtask

    task automatic check_order(input string name, input int e0, input int e1, input int e2, input int e3, input int n);
        int got [4];
        got = '{0, 0, 0, 0};
        for (int i = 0; i < order.size() && i < 4; i++) got[i] = order[i];
        check({name, " count"}, order.size(), n);
        check({name, " first"}, got[0], e0);
        check({name, " second"}, got[1], e1);
        if (n > 2) check({name, " third"}, got[2], e2);
        if (n > 3) check({name, " fourth"}, got[3], e3);
        check({name, " overlap"}, {31'd0, overlap}, 0);
    endtask

    task automatic run_b(input logic wr, output int lat, output int cey_lo, output logic [15:0] dx_seen);
        lat = -1; cey_lo = 0; dx_seen = 0;
        @(posedge CLK); #1;
        if (wr) b_CAP_REQ = 1; else b_USB_REQ = 1;
        for (int n = 0; n < 40; n++) begin
            @(negedge CLK);
            if (n > 0 && b_CEY === 1'b0) begin cey_lo++; dx_seen = b_DX; end
            if (b_CAP_ACK || b_USB_ACK) begin lat = n; break; end
        end
        @(posedge CLK); #1;
        b_CAP_REQ = 0; b_USB_REQ = 0;
    endtask

    initial begin
        int lat, cey_lo;
        logic found;
        logic [15:0] dxs;

        for (int i = 0; i < 1048576; i++) mem[i] = 16'h0000;
        mem[20'h00010] = 16'h1234;

        //            cap usb mat we  adr        wd       grant wr lat rd
        vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 20'h00010, 16'h0000, 2'd2, 1'b0, 4, 16'h1234};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 20'h40000, 16'hABCD, 2'd1, 1'b1, 4, 16'h0000};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 20'hFFFFF, 16'h0005, 2'd3, 1'b1, 4, 16'h0000};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 20'hFFFFF, 16'h0000, 2'd3, 1'b0, 4, 16'h0005};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 20'h40000, 16'h0000, 2'd2, 1'b0, 4, 16'hABCD};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 20'h00010, 16'h0000, 2'd3, 1'b0, 4, 16'h1234};

        // reset values
        repeat (2) @(negedge CLK);
        check("rst adx", {12'd0, ADX}, 0);
        check("rst cex_cey", {30'd0, CEX, CEY}, 3);
        check("rst enables", {28'd0, CE1, CE2, BHE, BLE}, 4'b0100);
        check("rst acks", {29'd0, CAP_ACK, USB_ACK, MAT_ACK}, 0);
        check("rst rd", {USB_RD, MAT_RD}, 0);
        check("rst grant_busy", {29'd0, GRANT, BUSY}, 0);
        @(posedge CLK); #1;
        RST = 0;
        @(negedge CLK);
        check("post_rst cex", {31'd0, CEX}, 0);
        check("post_rst busy", {31'd0, BUSY}, 0);

        for (int i = 0; i < 6; i++) run_vec(i);
        check("model 40000", {16'd0, mem[20'h40000]}, 16'hABCD);
        check("model fffff", {16'd0, mem[20'hFFFFF]}, 16'h0005);
        check("model 00000 no wrap", {16'd0, mem[20'h00000]}, 16'h0000);

        // all three at once; USB re-requests straight after its first ACK
        @(posedge CLK); #1;
        CAP_ADR = 20'h00100; CAP_WD = 16'h1111;
        USB_ADR = 20'h00010; MAT_ADR = 20'h00010; MAT_WE = 0;
        CAP_REQ = 1; USB_REQ = 1; MAT_REQ = 1;
        arb_run(4, 2);
        check_order("contention", 1, 2, 3, 2, 4);

        // reset in the middle of a CAP write pulse
        @(posedge CLK); #1;
        CAP_ADR = 20'h12345; CAP_WD = 16'h7777; CAP_REQ = 1;
        found = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge CLK);
            if (CEY === 1'b0) begin found = 1; break; end
        end
        check("abort reached wpulse", {31'd0, found}, 1);
        RST = 1; #1;
        check("abort cey", {31'd0, CEY}, 1);
        check("abort cex", {31'd0, CEX}, 1);
        check("abort busy_grant", {29'd0, GRANT, BUSY}, 0);
        check("abort cap_ack", {31'd0, CAP_ACK}, 0);
        @(posedge CLK); #1;
        check("abort no write", {16'd0, mem[20'h12345]}, 0);
        RST = 0;
        @(negedge CLK);
        check("abort release cex", {31'd0, CEX}, 0);
        lat = -1;
        for (int n = 1; n < 20; n++) begin
            @(negedge CLK);
            if (CAP_ACK) begin lat = n; break; end
        end
        @(posedge CLK); #1;
        CAP_REQ = 0;
        check("abort retry latency", lat, 4);
        @(posedge CLK); #1;
        check("abort retry data", {16'd0, mem[20'h12345]}, 16'h7777);

        // round-robin pointer back to USB after reset
        USB_ADR = 20'h00010; MAT_ADR = 20'h00010; MAT_WE = 0;
        USB_REQ = 1; MAT_REQ = 1;
        arb_run(2, 1);
        check_order("rr after reset", 2, 3, 0, 0, 2);

        // RD_WAIT = 15, WR_PULSE = 1 instance
        run_b(1'b0, lat, cey_lo, dxs);
        check("b read latency", lat, 17);
        check("b read cey", cey_lo, 0);
        check("b read data", {16'd0, b_USB_RD}, 16'h5A5A);
        run_b(1'b1, lat, cey_lo, dxs);
        check("b write latency", lat, 3);
        check("b write cey", cey_lo, 1);
        check("b write dx", {16'd0, dxs}, 16'hC3C3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
